// File: rtl/bird_pkg.sv
//==============================================================================
// Module      : bird_pkg
// Description : Shared state encoding and screen constants for the bird,
//               renderer and pipe generator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } bird_state_e;

    localparam int unsigned C_Y_MAX_DEF   = 464;
    localparam int unsigned C_Y_START_DEF = 240;

endpackage

`default_nettype wire

// File: rtl/bird_motion_ctrl_if.sv
//==============================================================================
// Module      : bird_motion_ctrl_if
// Description : Game-control inputs and sprite/score outputs of the bird block.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bird_motion_ctrl_if #(
    parameter int unsigned Y_W = 10
);
    logic           tick;
    logic           one_shot_button;
    logic           collision;
    logic           restart;
    logic [Y_W-1:0] bird_y;
    logic           en_subiendo;
    logic           falling;
    logic           dead;
    logic [1:0]     state;

    modport master (
        output tick, one_shot_button, collision, restart,
        input  bird_y, en_subiendo, falling, dead, state
    );

    modport slave (
        input  tick, one_shot_button, collision, restart,
        output bird_y, en_subiendo, falling, dead, state
    );
endinterface

`default_nettype wire

// File: rtl/bird_tick_timer.sv
//==============================================================================
// Module      : bird_tick_timer
// Description : Tick-enabled saturating rise counter; time_out_o is high once
//               RISE_TICKS ticks have been counted since the last clear.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bird_tick_timer #(
    parameter int unsigned RISE_TICKS = 8,
    parameter int unsigned CNT_W      = $clog2(RISE_TICKS + 1)
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en_i,
    input  wire logic clr_i,
    output logic      time_out_o
);

    localparam logic [CNT_W-1:0] c_term = CNT_W'(RISE_TICKS);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear and count in the same cycle yields 1: the clearing tick is itself
    // the first tick of the new rise.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end
        if (en_i && (cnt_d != c_term)) begin
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign time_out_o = (cnt_q == c_term);

endmodule

`default_nettype wire

// File: rtl/bird_motion_ctrl.sv
//==============================================================================
// Module      : bird_motion_ctrl
// Description : Bird vertical position/velocity controller with timed rise,
//               gravity fall, ceiling/ground limits and dead/restart.
//               Optional feature macro: FLAP_RETRIGGER_EN (flap in RISE
//               restarts the rise timer).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bird_motion_ctrl
    import bird_pkg::*;
#(
    parameter int unsigned Y_W        = 10,
    parameter int unsigned Y_MIN      = 0,
    parameter int unsigned Y_MAX      = C_Y_MAX_DEF,
    parameter int unsigned Y_START    = C_Y_START_DEF,
    parameter int unsigned RISE_TICKS = 8,
    parameter int unsigned RISE_STEP  = 4,
    parameter int unsigned VMAX       = 6,
    parameter int unsigned V_W        = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bird_motion_ctrl_if.slave bus
);

    localparam logic [Y_W:0]   c_y_min    = (Y_W + 1)'(Y_MIN);
    localparam logic [Y_W:0]   c_y_max    = (Y_W + 1)'(Y_MAX);
    localparam logic [Y_W:0]   c_step     = (Y_W + 1)'(RISE_STEP);
    localparam logic [Y_W:0]   c_up_floor = (Y_W + 1)'(Y_MIN + RISE_STEP);
    localparam logic [Y_W-1:0] c_y_start  = Y_W'(Y_START);
    localparam logic [V_W-1:0] c_vmax     = V_W'(VMAX);

    bird_state_e    state_q;
    bird_state_e    state_d;
    logic [Y_W-1:0] y_q;
    logic [Y_W-1:0] y_d;
    logic [V_W-1:0] vel_q;
    logic [V_W-1:0] vel_d;
    logic           flap_pend_q;
    logic           flap_pend_d;

    logic           w_flap;
    logic           w_tmr_en;
    logic           w_tmr_clr;
    logic           w_time_out;
    logic [Y_W:0]   w_y_ext;
    logic [Y_W:0]   w_up_raw;
    logic [Y_W:0]   w_dn_raw;
    logic [Y_W-1:0] w_y_up;
    logic [Y_W-1:0] w_y_dn;
    logic [V_W-1:0] w_vel_inc;

    // A flap arriving on the tick cycle itself is consumed by that tick.
    assign w_flap = flap_pend_q | bus.one_shot_button;

    // One extra bit of headroom so the upward step cannot wrap past zero.
    always_comb begin
        w_y_ext   = {1'b0, y_q};
        w_up_raw  = w_y_ext - c_step;
        w_y_up    = (w_y_ext < c_up_floor) ? c_y_min[Y_W-1:0] : w_up_raw[Y_W-1:0];
        w_vel_inc = (vel_q >= c_vmax) ? c_vmax : vel_q + 1'b1;
        w_dn_raw  = w_y_ext + (Y_W + 1)'(w_vel_inc);
        w_y_dn    = (w_dn_raw >= c_y_max) ? c_y_max[Y_W-1:0] : w_dn_raw[Y_W-1:0];
    end

    bird_tick_timer #(
        .RISE_TICKS (RISE_TICKS)
    ) u_rise_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (w_tmr_en),
        .clr_i      (w_tmr_clr),
        .time_out_o (w_time_out)
    );

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        vel_d       = vel_q;
        flap_pend_d = flap_pend_q | bus.one_shot_button;
        w_tmr_en    = 1'b0;
        w_tmr_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tick) begin
                    flap_pend_d = 1'b0;
                    if (w_flap) begin
                        state_d   = RISE;
                        y_d       = w_y_up;
                        vel_d     = '0;
                        w_tmr_clr = 1'b1;
                        w_tmr_en  = 1'b1;
                    end
                end
            end

            RISE: begin
                if (bus.tick) begin
                    flap_pend_d = 1'b0;
                    if (bus.collision) begin
                        state_d = DEAD;
`ifdef FLAP_RETRIGGER_EN
                    end else if (w_flap) begin
                        y_d       = w_y_up;
                        w_tmr_clr = 1'b1;
                        w_tmr_en  = 1'b1;
`endif
                    end else if (w_time_out) begin
                        state_d = FALL;
                        vel_d   = '0;
                    end else begin
                        y_d      = w_y_up;
                        w_tmr_en = 1'b1;
                    end
                end
            end

            FALL: begin
                if (bus.tick) begin
                    flap_pend_d = 1'b0;
                    if (bus.collision) begin
                        state_d = DEAD;
                    end else if (w_flap) begin
                        state_d   = RISE;
                        y_d       = w_y_up;
                        vel_d     = '0;
                        w_tmr_clr = 1'b1;
                        w_tmr_en  = 1'b1;
                    end else begin
                        vel_d = w_vel_inc;
                        y_d   = w_y_dn;
                        if (w_y_dn == c_y_max[Y_W-1:0]) begin
                            state_d = DEAD;
                        end
                    end
                end
            end

            DEAD: begin
                // Flaps are dropped while dead so none survive a restart.
                flap_pend_d = 1'b0;
                if (bus.restart) begin
                    state_d   = IDLE;
                    y_d       = c_y_start;
                    vel_d     = '0;
                    w_tmr_clr = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            y_q         <= c_y_start;
            vel_q       <= '0;
            flap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            flap_pend_q <= flap_pend_d;
        end
    end

    assign bus.bird_y      = y_q;
    assign bus.state       = state_q;
    assign bus.en_subiendo = (state_q == RISE);
    assign bus.falling     = (state_q == FALL);
    assign bus.dead        = (state_q == DEAD);

endmodule

`default_nettype wire

// File: tb/tb_bird_motion_ctrl.sv
//==============================================================================
// Module      : tb_bird_motion_ctrl
// Description : Self-checking bench for bird_motion_ctrl with a per-cycle
//               behavioural model and directed scenarios.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bird_motion_ctrl;

    localparam int Y_W        = 10;
    localparam int Y_MIN      = 0;
    localparam int Y_MAX      = 464;
    localparam int Y_START    = 240;
    localparam int RISE_TICKS = 8;
    localparam int RISE_STEP  = 4;
    localparam int VMAX       = 6;
`ifdef FLAP_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bird_motion_ctrl_if #(.Y_W(Y_W)) bus ();

    bird_motion_ctrl #(
        .Y_W        (Y_W),
        .Y_MIN      (Y_MIN),
        .Y_MAX      (Y_MAX),
        .Y_START    (Y_START),
        .RISE_TICKS (RISE_TICKS),
        .RISE_STEP  (RISE_STEP),
        .VMAX       (VMAX),
        .V_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: state as 0..3, rise tracked as "rise moves still to make".
    int m_st, m_y, m_v, m_left;
    bit m_flap;

    function automatic int up(input int y);
        return (y - RISE_STEP < Y_MIN) ? Y_MIN : y - RISE_STEP;
    endfunction

    always @(posedge clk or negedge rst) begin
        bit fl;
        if (!rst) begin
            m_st = 0; m_y = Y_START; m_v = 0; m_left = 0; m_flap = 1'b0;
        end else begin
            fl = m_flap || bus.one_shot_button;
            if (m_st == 3) begin
                m_flap = 1'b0;
                if (bus.restart) begin
                    m_st = 0; m_y = Y_START; m_v = 0;
                end
            end else if (bus.tick) begin
                m_flap = 1'b0;
                if (m_st == 0) begin
                    if (fl) begin m_st = 1; m_y = up(m_y); m_v = 0; m_left = RISE_TICKS - 1; end
                end else if (bus.collision) begin
                    m_st = 3;
                end else if (m_st == 1) begin
                    if (RETRIG && fl) begin
                        m_y = up(m_y); m_left = RISE_TICKS - 1;
                    end else if (m_left == 0) begin
                        m_st = 2; m_v = 0;
                    end else begin
                        m_y = up(m_y); m_left--;
                    end
                end else begin
                    if (fl) begin
                        m_st = 1; m_y = up(m_y); m_v = 0; m_left = RISE_TICKS - 1;
                    end else begin
                        m_v = (m_v + 1 > VMAX) ? VMAX : m_v + 1;
                        m_y = (m_y + m_v > Y_MAX) ? Y_MAX : m_y + m_v;
                        if (m_y == Y_MAX) m_st = 3;
                    end
                end
            end else begin
                m_flap = fl;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("model_y", int'(bus.bird_y), m_y);
            chk("model_state", int'(bus.state), m_st);
            chk("model_flags", int'({bus.en_subiendo, bus.falling, bus.dead}),
                int'({m_st == 1, m_st == 2, m_st == 3}));
        end
    end

    task automatic cyc(input bit t, input bit b, input bit c, input bit r);
        bus.tick = t; bus.one_shot_button = b; bus.collision = c; bus.restart = r;
        @(negedge clk);
        bus.tick = 1'b0; bus.one_shot_button = 1'b0; bus.collision = 1'b0; bus.restart = 1'b0;
    endtask

    initial begin
        int exp_fall [8] = '{209, 211, 214, 218, 223, 229, 235, 241};
        int n_rise;
        bit hit;
        bus.tick = 1'b0; bus.one_shot_button = 1'b0; bus.collision = 1'b0; bus.restart = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_y", int'(bus.bird_y), 240);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_flags", int'({bus.en_subiendo, bus.falling, bus.dead}), 0);
        rst = 1'b1;

        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("idle_hold_y", int'(bus.bird_y), 240);

        cyc(0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 0, 0);
            chk("rise_y", int'(bus.bird_y), 240 - 4 * k);
            chk("rise_flag", int'(bus.en_subiendo), 1);
        end
        cyc(1, 0, 0, 0);
        chk("rise_end_falling", int'(bus.falling), 1);
        chk("rise_end_y", int'(bus.bird_y), 208);

        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 0, 0);
            chk("gravity_y", int'(bus.bird_y), exp_fall[k]);
        end

        // Two flaps in one inter-tick gap act as one.
        cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("fall_flap_y", int'(bus.bird_y), 237);
        chk("fall_flap_rise", int'(bus.en_subiendo), 1);
        n_rise = 1;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, 0, 0);
            if (bus.en_subiendo) n_rise++;
            else break;
        end
        chk("double_flap_rise_len", n_rise, 8);
        chk("double_flap_top_y", int'(bus.bird_y), 209);

        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            cyc(1, 0, 0, 0);
            if (bus.dead) begin hit = 1'b1; break; end
        end
        chk("ground_reached", int'(hit), 1);
        chk("ground_y", int'(bus.bird_y), 464);
        cyc(0, 1, 0, 0); cyc(1, 0, 0, 0);
        chk("dead_ignores_flap", int'(bus.dead), 1);
        chk("dead_y_frozen", int'(bus.bird_y), 464);
        cyc(0, 0, 0, 1);
        chk("restart_state", int'(bus.state), 0);
        chk("restart_y", int'(bus.bird_y), 240);

        cyc(0, 1, 0, 0); cyc(1, 0, 0, 0);
        chk("start_y", int'(bus.bird_y), 236);
        cyc(0, 1, 0, 0); cyc(1, 0, 1, 0);
        chk("collision_state", int'(bus.state), 3);
        chk("collision_no_rise", int'(bus.bird_y), 236);
        cyc(0, 0, 0, 1);

        // Flap between rise ticks 5 and 6.
        cyc(0, 1, 0, 0); cyc(1, 0, 0, 0);
        n_rise = 1;
        for (int k = 0; k < 40; k++) begin
            if (k == 4) cyc(0, 1, 0, 0);
            cyc(1, 0, 0, 0);
            if (bus.en_subiendo) n_rise++;
            else break;
        end
        chk("retrigger_rise_len", n_rise, RETRIG ? 13 : 8);
        chk("retrigger_top_y", int'(bus.bird_y), RETRIG ? 188 : 208);

        #2 rst = 1'b0;
        #1;
        chk("async_reset_y", int'(bus.bird_y), 240);
        chk("async_reset_state", int'(bus.state), 0);
        @(negedge clk);
        rst = 1'b1;

        // Reach 214 (= 2 mod 4) so the climb ends with a 2 -> 0 clamp.
        cyc(0, 1, 0, 0);
        repeat (9) cyc(1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        chk("pre_climb_y", int'(bus.bird_y), 214);
        repeat (80) cyc(1, 1, 0, 0);
        chk("ceiling_clamp_y", int'(bus.bird_y), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
